// File: rtl/aclk_keybuf_n_pkg.sv
// Shared types and constants for the alarm-clock key-entry buffer.
//   state_e     : buffer FSM states (IDLE, ENTRY, HOLD)
//   DEF_*       : default digit count, key width and largest legal key code
//   clog2()     : ceil(log2(value)), usable in parameter expressions
package aclk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned DEF_DIGITS  = 4;
  localparam int unsigned DEF_DW      = 4;
  localparam int unsigned DEF_MAX_KEY = 9;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/aclk_keybuf_n_if.sv
// Keypad-side and consumer-side signals of the key-entry buffer.
//   master modport : keypad FSM / load logic side (drives strobes and out_ready)
//   slave modport  : the buffer itself
//   key_valid, key_data, backspace, clear, commit_req : one-cycle strobes in
//   out_ready                                         : consumer accepts out_data
//   key_buffer, digit_count                           : live entry
//   out_valid, out_data, busy                         : committed entry hand-off
//   err, timeout                                      : one-cycle status pulses
interface aclk_keybuf_n_if #(
  parameter int unsigned DIGITS = aclk_pkg::DEF_DIGITS,
  parameter int unsigned DW     = aclk_pkg::DEF_DW
);
  localparam int unsigned CW = aclk_pkg::clog2(DIGITS + 1);

  logic                 key_valid;
  logic [DW-1:0]        key_data;
  logic                 backspace;
  logic                 clear;
  logic                 commit_req;
  logic                 out_ready;
  logic [DIGITS*DW-1:0] key_buffer;
  logic [CW-1:0]        digit_count;
  logic                 out_valid;
  logic [DIGITS*DW-1:0] out_data;
  logic                 busy;
  logic                 err;
  logic                 timeout;

  modport master (
    output key_valid, key_data, backspace, clear, commit_req, out_ready,
    input  key_buffer, digit_count, out_valid, out_data, busy, err, timeout
  );

  modport slave (
    input  key_valid, key_data, backspace, clear, commit_req, out_ready,
    output key_buffer, digit_count, out_valid, out_data, busy, err, timeout
  );

endinterface

// File: rtl/aclk_idle_timer.sv
// Inactivity timer for the key-entry buffer.
//   clock, reset : system clock, asynchronous active-high reset
//   run          : count while high; counter is held at 0 while low
//   kick         : an operation was accepted this cycle; restart counting
//   expire       : combinational, high in the cycle the counter sits at
//                  TIMEOUT_CYC-1 with no kick (TIMEOUT_CYC == 0 never expires)
module aclk_idle_timer
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CntW    = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;
  localparam bit          Enabled = (TIMEOUT_CYC != 0);
  localparam logic [CntW-1:0] Last = (TIMEOUT_CYC > 0) ? CntW'(TIMEOUT_CYC - 1) : '0;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = Enabled && run && !kick && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!run || kick || expire) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aclk_keybuf_n.sv
// Key-entry buffer between the keypad FSM and the time/alarm load logic.
// Validated digits shift in at digit 0; backspace, clear and an inactivity
// timeout edit the entry; a full entry is handed off over a valid/ready pair.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : strobes, live buffer, committed entry and status pulses
// Strobe priority within a cycle: clear > commit_req > backspace > key_valid.
module aclk_keybuf_n
  import aclk_pkg::*;
#(
  parameter int unsigned DIGITS      = DEF_DIGITS,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned MAX_KEY     = DEF_MAX_KEY,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            clock,
  input  logic            reset,
  aclk_keybuf_n_if.slave  bus
);

  localparam int unsigned CW = clog2(DIGITS + 1);
  localparam int unsigned BW = DIGITS * DW;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  logic full, empty, key_ok, in_entry, kick, expire;

  assign full     = (cnt_q == CW'(DIGITS));
  assign empty    = (cnt_q == '0);
  assign key_ok   = (32'(bus.key_data) <= MAX_KEY);
  assign in_entry = (state_q == ENTRY);

  // Accepted operations in ENTRY restart the idle timer. Rejected strobes do
  // not, and lower-priority strobes shadowed by a higher one never count.
  assign kick = in_entry &&
                (bus.clear || (bus.commit_req && full) ||
                 (!bus.commit_req && (bus.backspace || (bus.key_valid && key_ok))));

  aclk_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .run    (in_entry),
    .kick   (kick),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE, ENTRY: begin
        if (bus.clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.commit_req) begin
          if (full) begin
            out_data_d  = buf_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.backspace) begin
          if (!empty) begin
            buf_d = {{DW{1'b0}}, buf_q[BW-1:DW]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.key_valid) begin
          if (key_ok) begin
            // Rolling entry: when full the oldest digit falls off the top.
            buf_d   = {buf_q[BW-DW-1:0], bus.key_data};
            if (!full) cnt_d = cnt_q + CW'(1);
            state_d = ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end
        // Expiry implies nothing was accepted above, so only an err pulse
        // from a rejected strobe can coexist with it.
        if (expire) begin
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.clear || (out_valid_q && bus.out_ready)) begin
          buf_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.key_buffer  = buf_q;
  assign bus.digit_count = cnt_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = (state_q == HOLD);
  assign bus.err         = err_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_aclk_keybuf_n.sv
module tb_aclk_keybuf_n;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned DW          = 4;
  localparam int unsigned MAX_KEY     = 9;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned BW          = DIGITS * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  aclk_keybuf_n_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

  aclk_keybuf_n #(
    .DIGITS      (DIGITS),
    .DW          (DW),
    .MAX_KEY     (MAX_KEY),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Behavioural model: digits as an int array, idle time as a plain count.
  int            m_dig[DIGITS];
  int            m_n;
  bit            m_hold, m_ov, m_err, m_to;
  logic [BW-1:0] m_od;
  int            m_idle;

  function automatic logic [BW-1:0] m_pack();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*DW +: DW] = DW'(m_dig[i]);
    return r;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
    m_n = 0;
  endtask

  task automatic model_reset();
    m_zero();
    m_hold = 0; m_ov = 0; m_err = 0; m_to = 0; m_od = '0; m_idle = 0;
  endtask

  task automatic model_step();
    bit acc, was_entry;
    int kd;
    m_err = 0;
    m_to  = 0;
    if (m_hold) begin
      if (bus.clear || bus.out_ready) begin
        m_zero(); m_hold = 0; m_ov = 0;
      end
      m_idle = 0;
    end else begin
      was_entry = (m_n > 0);
      acc = 0;
      kd  = int'(bus.key_data);
      if (bus.clear) begin
        m_zero(); acc = 1;
      end else if (bus.commit_req) begin
        if (m_n == DIGITS) begin
          m_od = m_pack(); m_ov = 1; m_hold = 1; acc = 1;
        end else m_err = 1;
      end else if (bus.backspace) begin
        if (m_n > 0) begin
          for (int i = 0; i < DIGITS - 1; i++) m_dig[i] = m_dig[i+1];
          m_dig[DIGITS-1] = 0; m_n--; acc = 1;
        end else m_err = 1;
      end else if (bus.key_valid) begin
        if (kd <= MAX_KEY) begin
          for (int i = DIGITS - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = kd;
          if (m_n < DIGITS) m_n++;
          acc = 1;
        end else m_err = 1;
      end
      if (was_entry) begin
        if (acc) m_idle = 0;
        else begin
          m_idle++;
          if (TIMEOUT_CYC != 0 && m_idle == TIMEOUT_CYC) begin
            m_zero(); m_to = 1;
          end
        end
      end
      if (m_n == 0 || m_hold) m_idle = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("key_buffer", 32'(bus.key_buffer), 32'(m_pack()));
      check("digit_count", 32'(bus.digit_count), 32'(m_n));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      if (m_ov) check("out_data", 32'(bus.out_data), 32'(m_od));
      check("busy", 32'(bus.busy), 32'(m_hold));
      check("err", 32'(bus.err), 32'(m_err));
      check("timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic strobes_off();
    bus.key_valid = 0; bus.backspace = 0; bus.clear = 0; bus.commit_req = 0;
  endtask

  task automatic press(input int k);
    bus.key_valid = 1; bus.key_data = DW'(k); tick(); bus.key_valid = 0;
  endtask

  task automatic bsp();
    bus.backspace = 1; tick(); bus.backspace = 0;
  endtask

  task automatic clr();
    bus.clear = 1; tick(); bus.clear = 0;
  endtask

  task automatic commit();
    bus.commit_req = 1; tick(); bus.commit_req = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_buffer"}, 32'(bus.key_buffer), 32'h0);
    check({tag, "_digit_count"}, 32'(bus.digit_count), 32'h0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_err"}, 32'(bus.err), 32'h0);
    check({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    int quiet;
    strobes_off();
    bus.key_data  = '0;
    bus.out_ready = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset  = 0;
    chk_en = 1;

    // Shift-in and rolling entry
    press(1); press(2); press(3); press(4);
    check("keys_1234", 32'(bus.key_buffer), 32'h1234);
    check("keys_1234_count", 32'(bus.digit_count), 32'd4);
    check("model_1234", 32'(m_pack()), 32'h1234);
    press(5);
    check("roll_2345", 32'(bus.key_buffer), 32'h2345);
    check("roll_count", 32'(bus.digit_count), 32'd4);
    check("roll_no_err", 32'(bus.err), 32'h0);

    // Backspace
    clr(); press(7); press(8); bsp();
    check("bs_0007", 32'(bus.key_buffer), 32'h0007);
    check("bs_count", 32'(bus.digit_count), 32'd1);
    bsp();
    check("bs_empty_count", 32'(bus.digit_count), 32'd0);
    check("bs_empty_no_err", 32'(bus.err), 32'h0);
    bsp();
    check("bs_underflow_err", 32'(bus.err), 32'h1);

    // Illegal key and short commit
    press(1); press(2); press(3); press(11);
    check("badkey_err", 32'(bus.err), 32'h1);
    check("badkey_buffer", 32'(bus.key_buffer), 32'h0123);
    commit();
    check("short_commit_err", 32'(bus.err), 32'h1);
    check("short_commit_ov", 32'(bus.out_valid), 32'h0);

    // Commit with back-pressure
    clr(); press(1); press(2); press(3); press(0);
    commit();
    check("hold_ov", 32'(bus.out_valid), 32'h1);
    check("hold_od", 32'(bus.out_data), 32'h1230);
    check("hold_busy", 32'(bus.busy), 32'h1);
    check("model_od", 32'(m_od), 32'h1230);
    for (int i = 0; i < 5; i++) begin
      bus.key_valid = 1; bus.key_data = 4'd9; bus.backspace = (i == 2);
      tick();
      check("hold_od_stable", 32'(bus.out_data), 32'h1230);
      check("hold_keys_ignored", 32'(bus.key_buffer), 32'h1230);
      check("hold_no_err", 32'(bus.err), 32'h0);
    end
    strobes_off();
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    check("accept_ov", 32'(bus.out_valid), 32'h0);
    check("accept_buffer", 32'(bus.key_buffer), 32'h0);
    check("accept_busy", 32'(bus.busy), 32'h0);

    // Inactivity timeout and strobe on the expiry cycle
    press(6);
    repeat (7) tick();
    check("pre_timeout", 32'(bus.timeout), 32'h0);
    tick();
    check("timeout_pulse", 32'(bus.timeout), 32'h1);
    check("timeout_cleared", 32'(bus.key_buffer), 32'h0);
    press(6);
    repeat (7) tick();
    press(3);
    check("expiry_key_wins", 32'(bus.timeout), 32'h0);
    check("expiry_key_buffer", 32'(bus.key_buffer), 32'h0063);

    // Clear beats key in the same cycle
    bus.clear = 1; bus.key_valid = 1; bus.key_data = 4'd5;
    tick(); strobes_off();
    check("clear_beats_key", 32'(bus.key_buffer), 32'h0);

    // Reset while holding a committed entry
    press(1); press(2); press(3); press(4); commit();
    check("pre_reset_ov", 32'(bus.out_valid), 32'h1);
    pulse_reset();

    // Randomised traffic against the model
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet > 0) begin
        strobes_off();
        quiet--;
      end else begin
        bus.clear      = ($urandom_range(0, 99) < 3);
        bus.commit_req = ($urandom_range(0, 99) < 8);
        bus.backspace  = ($urandom_range(0, 99) < 8);
        bus.key_valid  = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(5, 12);
      end
      bus.key_data  = DW'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 99) < 30);
      tick();
      if (c == 1500) begin
        strobes_off();
        bus.out_ready = 0;
        pulse_reset();
      end
    end
    strobes_off();
    bus.out_ready = 0;
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
